round_manager: RTL and testbench
================================

ROUND_MANAGER -- requirements
Module: round_manager

Interface
REQ-001 Parameter INIT_CREDITS, default 100, credit balance loaded at reset (1..255).
REQ-002 Parameter TIMEOUT_CYCLES, default 15, max PLAY cycles before abort (1..15).
REQ-003 slow_clock  input  1  sole clock, rising-edge.
REQ-004 resetb  input  1  reset, asynchronous, active-low.
REQ-005 deal_req  input  1  player deal button, active-high level.
REQ-006 bet_side  input  2  bet choice: 0 player, 1 dealer, 2 tie, 3 no bet.
REQ-007 bet_amt  input  4  wager, 0..15 credits.
REQ-008 player_win_light  input  1  round-sequencer player result.
REQ-009 dealer_win_light  input  1  round-sequencer dealer result.
REQ-010 round_resetb  output  1  active-low synchronous restart for round sequencer.
REQ-011 busy  output  1  high from deal accept until settle complete.
REQ-012 credits  output  8  current balance.
REQ-013 pwins / dwins / ties  output  4 each  saturating round tallies.
REQ-014 timeout_err  output  1  sticky abort flag, cleared by next accepted deal.
REQ-015 game_over  output  1  high while credits == 0.

Function
REQ-016 States IDLE, CLEAR, PLAY, SETTLE, HOLD, OVER, encoded per shared package.
REQ-017 IDLE: deal accepted on deal_req rising edge (one per press); accept latches bet_side and effective bet = min(bet_amt, credits); -> CLEAR.
REQ-018 CLEAR: round_resetb = 0 for exactly one cycle; -> PLAY; round_resetb = 1 in every other state.
REQ-019 PLAY: result valid when either light high; -> SETTLE next cycle; cycle counter starts at 0 on PLAY entry.
REQ-020 SETTLE (one cycle) classifies: both lights = tie, player only = player, dealer only = dealer.
REQ-021 Payout: winning side bet +bet; losing side bet -bet; tie on side bet = push (no change); tie bet on tie +8*bet; tie bet on non-tie -bet; bet_side 3 no change.
REQ-022 credits saturates at 255 on add; subtraction cannot underflow (bet clamped at accept).
REQ-023 Matching tally increments once per SETTLE, saturating at 15.
REQ-024 SETTLE -> OVER if new credits == 0, else -> HOLD.
REQ-025 HOLD: waits deal_req low, -> IDLE (prevents held button re-dealing).
REQ-026 OVER: absorbing; ignores deal_req; exit only by resetb.
REQ-027 busy = 1 in CLEAR, PLAY, SETTLE; 0 otherwise.
REQ-028 deal_req during busy ignored; edge detector still tracks level.

Reset
REQ-029 resetb low: state IDLE, credits = INIT_CREDITS, tallies 0, timeout_err 0, round_resetb 0 (sequencer held in reset), busy 0, edge-detect history 1 (button held through reset gives no deal).
REQ-030 resetb mid-round discards pending bet; no payout applied.

Configuration
REQ-031 ROUND_TIMEOUT_EN defined: PLAY counting TIMEOUT_CYCLES cycles with no light -> IDLE, timeout_err = 1, credits/tallies unchanged.
REQ-032 ROUND_TIMEOUT_EN undefined: no counter; PLAY waits indefinitely; timeout_err tied 0.

Structure
REQ-033 Package round_pkg: state enum, bet_side enum, TALLY_MAX, CREDIT_MAX, TIE_PAYOUT = 8.
REQ-034 Sub-module rise_detect (1-bit registered rising-edge detector, async reset value parameterizable) used for deal_req.

Verification
REQ-035 Reset, credits 100; deal, bet player 10, player light only -> credits 110, pwins 1, round_resetb low exactly 1 cycle after accept.
REQ-036 Credits 5, bet dealer 15, player wins -> bet clamped 5, credits 0, game_over 1, later deal ignored.
REQ-037 Bet tie 15 from 250, both lights -> credits 255 (saturated), ties 1; bet player with tie -> credits unchanged.
REQ-038 deal_req held high 20 cycles -> exactly one round; second round only after release and re-press.
REQ-039 With ROUND_TIMEOUT_EN, lights never assert -> IDLE after 15 PLAY cycles, timeout_err 1, credits unchanged; next deal clears flag.
REQ-040 16 player wins -> pwins holds 15; resetb asserted during PLAY -> IDLE, credits = INIT_CREDITS.

Source files
------------

// File: rtl/round_pkg.sv
// Shared definitions for the round manager: FSM state codes, bet sides,
// tally/credit limits and the tie payout multiplier.
package round_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_PLAY   = 3'd2;
  localparam logic [2:0] ST_SETTLE = 3'd3;
  localparam logic [2:0] ST_HOLD   = 3'd4;
  localparam logic [2:0] ST_OVER   = 3'd5;

  typedef enum logic [1:0] {
    BET_PLAYER = 2'd0,
    BET_DEALER = 2'd1,
    BET_TIE    = 2'd2,
    BET_NONE   = 2'd3
  } bet_side_e;

  localparam logic [3:0] TALLY_MAX  = 4'd15;
  localparam logic [7:0] CREDIT_MAX = 8'd255;
  localparam int         TIE_PAYOUT = 8;

  // Tallies stick at TALLY_MAX instead of wrapping back to zero.
  function automatic logic [3:0] tally_inc(input logic [3:0] t);
    return (t == TALLY_MAX) ? t : t + 4'd1;
  endfunction

endpackage

// File: rtl/round_manager_rise_detect.sv
// One-bit registered rising-edge detector. RESET_VAL = 1 makes a level that
// is already high when reset releases look like "no new edge".
module rise_detect #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);

  logic hist_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) hist_q <= RESET_VAL;
    else         hist_q <= d_i;
  end

  assign rise_o = d_i & ~hist_q;

endmodule

// File: rtl/round_manager.sv
// Betting round manager: accepts deals, restarts the round sequencer, settles
// wagers and tallies. Optional PLAY watchdog enabled by `define ROUND_TIMEOUT_EN.
module round_manager
  import round_pkg::*;
#(
  parameter int INIT_CREDITS   = 100,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic       deal_req,
  input  logic [1:0] bet_side,
  input  logic [3:0] bet_amt,
  input  logic       player_win_light,
  input  logic       dealer_win_light,
  output logic       round_resetb,
  output logic       busy,
  output logic [7:0] credits,
  output logic [3:0] pwins,
  output logic [3:0] dwins,
  output logic [3:0] ties,
  output logic       timeout_err,
  output logic       game_over
);

  logic [2:0] state_q, state_d;
  bet_side_e  side_q, side_d;
  logic [3:0] bet_q, bet_d;
  logic       plight_q, plight_d, dlight_q, dlight_d;
  logic [7:0] credits_q, credits_d;
  logic [3:0] pwins_q, pwins_d, dwins_q, dwins_d, ties_q, ties_d;
  logic       rrb_q;
  logic       deal_rise;
  logic [3:0] eff_bet;
  logic       res_tie, res_player, res_dealer;
  logic [9:0] gain, sum;
  logic [3:0] loss;
  logic [7:0] settled;

`ifdef ROUND_TIMEOUT_EN
  localparam logic [3:0] TIMEOUT_LAST = 4'(TIMEOUT_CYCLES - 1);
  logic [3:0] cnt_q, cnt_d;
  logic       terr_q, terr_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^4'(TIMEOUT_CYCLES);
`endif

  rise_detect #(.RESET_VAL(1'b1)) u_deal_edge (
    .clk_i  (slow_clock),
    .rst_ni (resetb),
    .d_i    (deal_req),
    .rise_o (deal_rise)
  );

  assign eff_bet    = ({4'd0, bet_amt} > credits_q) ? credits_q[3:0] : bet_amt;
  assign res_tie    = plight_q & dlight_q;
  assign res_player = plight_q & ~dlight_q;
  assign res_dealer = dlight_q & ~plight_q;

  // Wins add (and may saturate); losses were clamped at accept so cannot underflow.
  always_comb begin
    gain = '0;
    loss = '0;
    case (side_q)
      BET_PLAYER: if (res_player) gain = {6'd0, bet_q}; else if (res_dealer) loss = bet_q;
      BET_DEALER: if (res_dealer) gain = {6'd0, bet_q}; else if (res_player) loss = bet_q;
      BET_TIE:    if (res_tie) gain = 10'(TIE_PAYOUT) * {6'd0, bet_q}; else loss = bet_q;
      default: ;
    endcase
  end

  assign sum     = {2'b00, credits_q} + gain;
  assign settled = (gain != '0) ? ((sum > {2'b00, CREDIT_MAX}) ? CREDIT_MAX : sum[7:0])
                                : credits_q - {4'd0, loss};

  always_comb begin
    state_d   = state_q;
    side_d    = side_q;
    bet_d     = bet_q;
    plight_d  = plight_q;
    dlight_d  = dlight_q;
    credits_d = credits_q;
    pwins_d   = pwins_q;
    dwins_d   = dwins_q;
    ties_d    = ties_q;
`ifdef ROUND_TIMEOUT_EN
    terr_d    = terr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (deal_rise) begin
          state_d = ST_CLEAR;
          side_d  = bet_side_e'(bet_side);
          bet_d   = eff_bet;
`ifdef ROUND_TIMEOUT_EN
          terr_d  = 1'b0;
`endif
        end
      end
      ST_CLEAR: state_d = ST_PLAY;
      ST_PLAY: begin
        if (player_win_light || dealer_win_light) begin
          state_d  = ST_SETTLE;
          plight_d = player_win_light;
          dlight_d = dealer_win_light;
        end
`ifdef ROUND_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_LAST) begin
          state_d = ST_IDLE;
          terr_d  = 1'b1;
        end
`endif
      end
      ST_SETTLE: begin
        credits_d = settled;
        if (res_tie)    ties_d  = tally_inc(ties_q);
        if (res_player) pwins_d = tally_inc(pwins_q);
        if (res_dealer) dwins_d = tally_inc(dwins_q);
        state_d = (settled == 8'd0) ? ST_OVER : ST_HOLD;
      end
      ST_HOLD:  if (!deal_req) state_d = ST_IDLE;
      ST_OVER:  state_d = ST_OVER;
      default:  state_d = ST_IDLE;
    endcase
  end

  // round_resetb is registered so the sequencer sees a clean, glitch-free pulse.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state_q   <= ST_IDLE;
      side_q    <= BET_NONE;
      bet_q     <= '0;
      plight_q  <= 1'b0;
      dlight_q  <= 1'b0;
      credits_q <= 8'(INIT_CREDITS);
      pwins_q   <= '0;
      dwins_q   <= '0;
      ties_q    <= '0;
      rrb_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      side_q    <= side_d;
      bet_q     <= bet_d;
      plight_q  <= plight_d;
      dlight_q  <= dlight_d;
      credits_q <= credits_d;
      pwins_q   <= pwins_d;
      dwins_q   <= dwins_d;
      ties_q    <= ties_d;
      rrb_q     <= (state_d != ST_CLEAR);
    end
  end

`ifdef ROUND_TIMEOUT_EN
  assign cnt_d = (state_q == ST_PLAY) ? cnt_q + 4'd1 : 4'd0;

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      cnt_q  <= '0;
      terr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      terr_q <= terr_d;
    end
  end

  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign round_resetb = rrb_q;
  assign busy         = (state_q == ST_CLEAR) || (state_q == ST_PLAY) || (state_q == ST_SETTLE);
  assign credits      = credits_q;
  assign pwins        = pwins_q;
  assign dwins        = dwins_q;
  assign ties         = ties_q;
  assign game_over    = (credits_q == 8'd0);

endmodule

// File: tb/tb_round_manager.sv
// Directed bench for round_manager: table of single rounds plus hand-written
// sequences for clamping, saturation, held button, mid-round reset and timeout.
module tb_round_manager;

  logic       slow_clock = 1'b0;
  logic       resetb;
  logic       deal_req;
  logic [1:0] bet_side;
  logic [3:0] bet_amt;
  logic       player_win_light;
  logic       dealer_win_light;
  logic       round_resetb;
  logic       busy;
  logic [7:0] credits;
  logic [3:0] pwins, dwins, ties;
  logic       timeout_err;
  logic       game_over;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] side;
    logic [3:0] amt;
    logic       pl;
    logic       dl;
    int         expCredits;
    int         expP;
    int         expD;
    int         expT;
  } vec_t;

  vec_t vecs[10];

  round_manager dut (
    .slow_clock       (slow_clock),
    .resetb           (resetb),
    .deal_req         (deal_req),
    .bet_side         (bet_side),
    .bet_amt          (bet_amt),
    .player_win_light (player_win_light),
    .dealer_win_light (dealer_win_light),
    .round_resetb     (round_resetb),
    .busy             (busy),
    .credits          (credits),
    .pwins            (pwins),
    .dwins            (dwins),
    .ties             (ties),
    .timeout_err      (timeout_err),
    .game_over        (game_over)
  );

  always #5 slow_clock = ~slow_clock;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic doReset();
    resetb = 1'b0;
    deal_req = 1'b0;
    bet_side = 2'd3;
    bet_amt = 4'd0;
    player_win_light = 1'b0;
    dealer_win_light = 1'b0;
    @(negedge slow_clock);
    @(negedge slow_clock);
    resetb = 1'b1;
    @(negedge slow_clock);
  endtask

  // One complete round, called and returning just after a negedge in IDLE.
  task automatic applyStimulus(input logic [1:0] side, input logic [3:0] amt,
                               input logic pl, input logic dl);
    bet_side = side;
    bet_amt  = amt;
    deal_req = 1'b1;
    @(negedge slow_clock);
    checkOutput("accept_busy", busy, 1);
    checkOutput("clear_rrb_low", round_resetb, 0);
    deal_req = 1'b0;
    @(negedge slow_clock);
    checkOutput("play_rrb_high", round_resetb, 1);
    player_win_light = pl;
    dealer_win_light = dl;
    @(negedge slow_clock);
    player_win_light = 1'b0;
    dealer_win_light = 1'b0;
    @(negedge slow_clock);
    @(negedge slow_clock);
    checkOutput("done_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rrbLow;

    vecs[0] = '{2'd0, 4'd10, 1'b1, 1'b0, 110, 1, 0, 0};
    vecs[1] = '{2'd1, 4'd5,  1'b1, 1'b0, 105, 2, 0, 0};
    vecs[2] = '{2'd1, 4'd7,  1'b0, 1'b1, 112, 2, 1, 0};
    vecs[3] = '{2'd2, 4'd3,  1'b1, 1'b1, 136, 2, 1, 1};
    vecs[4] = '{2'd0, 4'd9,  1'b1, 1'b1, 136, 2, 1, 2};
    vecs[5] = '{2'd2, 4'd2,  1'b0, 1'b1, 134, 2, 2, 2};
    vecs[6] = '{2'd3, 4'd15, 1'b1, 1'b0, 134, 3, 2, 2};
    vecs[7] = '{2'd0, 4'd15, 1'b0, 1'b1, 119, 3, 3, 2};
    vecs[8] = '{2'd0, 4'd0,  1'b1, 1'b0, 119, 4, 3, 2};
    vecs[9] = '{2'd1, 4'd12, 1'b1, 1'b1, 119, 4, 3, 3};

    // Reset values while resetb is held low.
    resetb = 1'b0;
    deal_req = 1'b0;
    bet_side = 2'd3;
    bet_amt = 4'd0;
    player_win_light = 1'b0;
    dealer_win_light = 1'b0;
    @(negedge slow_clock);
    checkOutput("rst_rrb", round_resetb, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_credits", credits, 100);
    checkOutput("rst_pwins", pwins, 0);
    checkOutput("rst_ties", ties, 0);
    checkOutput("rst_terr", timeout_err, 0);
    checkOutput("rst_over", game_over, 0);
    resetb = 1'b1;
    @(negedge slow_clock);
    checkOutput("post_rst_rrb", round_resetb, 1);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].side, vecs[i].amt, vecs[i].pl, vecs[i].dl);
      checkOutput($sformatf("vec%0d_credits", i), credits, vecs[i].expCredits);
      checkOutput($sformatf("vec%0d_pwins", i), pwins, vecs[i].expP);
      checkOutput($sformatf("vec%0d_dwins", i), dwins, vecs[i].expD);
      checkOutput($sformatf("vec%0d_ties", i), ties, vecs[i].expT);
    end

    // Tie payout saturating at 255, then push on a side bet.
    doReset();
    applyStimulus(2'd2, 4'd15, 1'b1, 1'b1);
    checkOutput("sat_tie1", credits, 220);
    applyStimulus(2'd0, 4'd15, 1'b1, 1'b0);
    applyStimulus(2'd0, 4'd15, 1'b1, 1'b0);
    checkOutput("sat_250", credits, 250);
    applyStimulus(2'd2, 4'd15, 1'b1, 1'b1);
    checkOutput("sat_255", credits, 255);
    checkOutput("sat_ties", ties, 2);
    applyStimulus(2'd0, 4'd5, 1'b1, 1'b1);
    checkOutput("push_credits", credits, 255);
    checkOutput("push_ties", ties, 3);

    // Drain to 5 credits, then a clamped losing bet ends the game.
    doReset();
    for (int i = 0; i < 6; i++) applyStimulus(2'd0, 4'd15, 1'b0, 1'b1);
    checkOutput("drain_10", credits, 10);
    applyStimulus(2'd0, 4'd5, 1'b0, 1'b1);
    checkOutput("drain_5", credits, 5);
    applyStimulus(2'd1, 4'd15, 1'b1, 1'b0);
    checkOutput("clamp_credits", credits, 0);
    checkOutput("clamp_over", game_over, 1);
    checkOutput("clamp_pwins", pwins, 1);
    deal_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge slow_clock);
      checkOutput("over_busy", busy, 0);
      checkOutput("over_rrb", round_resetb, 1);
    end
    deal_req = 1'b0;
    @(negedge slow_clock);
    checkOutput("over_credits", credits, 0);

    // Tally saturation with zero bets.
    doReset();
    for (int i = 0; i < 15; i++) applyStimulus(2'd0, 4'd0, 1'b1, 1'b0);
    checkOutput("tally_15", pwins, 15);
    applyStimulus(2'd0, 4'd0, 1'b1, 1'b0);
    checkOutput("tally_hold15", pwins, 15);
    checkOutput("tally_credits", credits, 100);

    // Button held 20 cycles yields exactly one round.
    doReset();
    bet_side = 2'd0;
    bet_amt = 4'd1;
    player_win_light = 1'b1;
    deal_req = 1'b1;
    rrbLow = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge slow_clock);
      if (round_resetb == 1'b0) rrbLow++;
    end
    checkOutput("held_rounds", rrbLow, 1);
    checkOutput("held_credits", credits, 101);
    checkOutput("held_pwins", pwins, 1);
    checkOutput("held_busy", busy, 0);
    deal_req = 1'b0;
    player_win_light = 1'b0;
    @(negedge slow_clock);
    @(negedge slow_clock);
    applyStimulus(2'd0, 4'd1, 1'b1, 1'b0);
    checkOutput("repress_credits", credits, 102);
    checkOutput("repress_pwins", pwins, 2);

    // Reset during PLAY discards the pending bet.
    bet_side = 2'd0;
    bet_amt = 4'd10;
    deal_req = 1'b1;
    @(negedge slow_clock);
    deal_req = 1'b0;
    @(negedge slow_clock);
    @(negedge slow_clock);
    checkOutput("midplay_busy", busy, 1);
    resetb = 1'b0;
    #1;
    checkOutput("midrst_credits", credits, 100);
    checkOutput("midrst_pwins", pwins, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_rrb", round_resetb, 0);
    @(negedge slow_clock);
    resetb = 1'b1;
    @(negedge slow_clock);

`ifdef ROUND_TIMEOUT_EN
    // Lights never come: 15 PLAY cycles, then back to IDLE with the flag set.
    doReset();
    bet_side = 2'd0;
    bet_amt = 4'd5;
    deal_req = 1'b1;
    @(negedge slow_clock);
    deal_req = 1'b0;
    repeat (15) @(negedge slow_clock);
    checkOutput("to_still_busy", busy, 1);
    @(negedge slow_clock);
    checkOutput("to_busy", busy, 0);
    checkOutput("to_flag", timeout_err, 1);
    checkOutput("to_credits", credits, 100);
    applyStimulus(2'd0, 4'd5, 1'b1, 1'b0);
    checkOutput("to_cleared", timeout_err, 0);
    checkOutput("to_next_credits", credits, 105);
`else
    checkOutput("no_to_flag", timeout_err, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
